// File: rtl/cbus_rx_pma_prbs_chk.sv
// PRBS checker for the Cbus receive PMA: self-seeds from the incoming stream, verifies, then
// free-runs its LFSR while locked, flagging and counting bit errors with windowed loss-of-lock.
module cbus_rx_pma_prbs_chk #(
  parameter int N          = 31,
  parameter int TAP        = 28,
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 256,
  parameter int ERR_THRESH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        din,
  input  logic        clr,
  output logic        locked,
  output logic        err,
  output logic [31:0] err_cnt,
  output logic [31:0] bit_cnt
);

  localparam int SW = $clog2(N + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);

  localparam logic [SW-1:0] SEED_LAST  = SW'(N - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LIMIT  = EW'(ERR_THRESH);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:N]    lfsr_q, lfsr_d;
  logic [SW-1:0] seed_q, seed_d;
  logic [MW-1:0] match_q, match_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] werr_q, werr_d;

  logic pred;
  logic mism;
  logic fb;
  logic chk_bit;

  assign pred    = lfsr_q[TAP] ^ lfsr_q[N];
  assign mism    = din ^ pred;
  assign chk_bit = ce && (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    fb      = din;
    if (ce) begin
      case (state_q)
        SEED: begin
          if (seed_q == SEED_LAST) begin
            seed_d = '0;
            // an all-zero seed would self-predict zeros forever, so keep seeding
            if ({din, lfsr_q[1:N-1]} != '0) state_d = VERIFY;
          end else begin
            seed_d = seed_q + SW'(1);
          end
        end
        VERIFY: begin
          if (!mism) begin
            if (match_q == MATCH_LAST) begin
              match_d = '0;
              state_d = LOCKED;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
            seed_d  = '0;
            state_d = SEED;
          end
        end
        LOCKED: begin
          fb = pred;
          // the bit that wraps the window is counted in the new window
          if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = EW'(mism);
          end else begin
            win_d  = win_q + WW'(1);
            werr_d = werr_q + EW'(mism);
          end
          if (werr_d == ERR_LIMIT) begin
            state_d = SEED;
            seed_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end
        end
        default: state_d = SEED;
      endcase
      lfsr_d = {fb, lfsr_q[1:N-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
      lfsr_q  <= '0;
      seed_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
    end
  end

  // registered outputs: one clk behind the sampled bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      locked <= (state_q == LOCKED);
      err    <= chk_bit && mism;
      if (clr) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        if (chk_bit && mism && (err_cnt != '1)) err_cnt <= err_cnt + 32'd1;
        if (chk_bit && (bit_cnt != '1))         bit_cnt <= bit_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cbus_rx_pma_prbs_chk.sv
// Scoreboard bench for cbus_rx_pma_prbs_chk: driver pushes model expectations per clock,
// monitor pops and compares each cycle; directed checks cover lock latency and thresholds.
module tb_cbus_rx_pma_prbs_chk;

  localparam int N          = 31;
  localparam int TAP        = 28;
  localparam int LOCK_CNT   = 64;
  localparam int WINDOW     = 256;
  localparam int ERR_THRESH = 16;
  localparam longint MAXC   = 64'hFFFF_FFFF;

  localparam int M_SEED   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        din = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic        err;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;

  cbus_rx_pma_prbs_chk #(
    .N(N), .TAP(TAP), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     lk;
    bit     er;
    longint ec;
    longint bc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     m_mode, m_seedn, m_matchn, m_wn, m_werr;
  bit     m_hist[N];          // m_hist[0] = most recent bit
  longint m_ecnt, m_bcnt;
  bit     m_locked, m_err;

  task automatic model_reset();
    m_mode = M_SEED; m_seedn = 0; m_matchn = 0; m_wn = 0; m_werr = 0;
    for (int i = 0; i < N; i++) m_hist[i] = 1'b0;
    m_ecnt = 0; m_bcnt = 0; m_locked = 1'b0; m_err = 1'b0;
  endtask

  function automatic bit hist_nonzero();
    for (int i = 0; i < N; i++) if (m_hist[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit p, mm, was_locked;
    exp_t e;
    if (!rst_n) begin
      model_reset();
    end else begin
      was_locked = (m_mode == M_LOCKED);
      m_err = 1'b0;
      if (ce) begin
        p  = m_hist[TAP-1] ^ m_hist[N-1];
        mm = din ^ p;
        for (int i = N-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = was_locked ? p : din;
        case (m_mode)
          M_SEED: begin
            m_seedn++;
            if (m_seedn == N) begin
              m_seedn = 0;
              if (hist_nonzero()) m_mode = M_VERIFY;
            end
          end
          M_VERIFY: begin
            if (!mm) begin
              m_matchn++;
              if (m_matchn == LOCK_CNT) begin
                m_matchn = 0; m_mode = M_LOCKED; m_wn = 0; m_werr = 0;
              end
            end else begin
              m_matchn = 0; m_mode = M_SEED; m_seedn = 0;
            end
          end
          default: begin
            m_err = mm;
            if (mm && m_ecnt < MAXC) m_ecnt++;
            if (m_bcnt < MAXC) m_bcnt++;
            if (m_wn == WINDOW-1) begin
              m_wn = 0; m_werr = int'(mm);
            end else begin
              m_wn++; m_werr += int'(mm);
            end
            if (m_werr >= ERR_THRESH) begin
              m_mode = M_SEED; m_seedn = 0; m_wn = 0; m_werr = 0;
            end
          end
        endcase
      end
      if (clr) begin
        m_ecnt = 0; m_bcnt = 0;
      end
      m_locked = was_locked;
    end
    e.lk = m_locked; e.er = m_err; e.ec = m_ecnt; e.bc = m_bcnt;
    sbq.push_back(e);
  endtask

  // ---------------- PRBS source: x[k] = x[k-TAP] ^ x[k-N] ----------------
  bit gq[$];
  int gen_n = 0;

  function automatic bit next_prbs();
    bit b;
    if (gen_n < N) begin
      b = gq[gen_n];
    end else begin
      b = gq[gq.size()-TAP] ^ gq[gq.size()-N];
      gq.push_back(b);
      void'(gq.pop_front());
    end
    gen_n++;
    return b;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit c, input bit d, input bit cl);
    ce = c; din = d; clr = cl;
    model_step();
    @(negedge clk);
  endtask

  task automatic send(input bit inv, input bit cl);
    drive(1'b1, next_prbs() ^ inv, cl);
  endtask

  task automatic lock_run(input string name);
    int n = 0;
    while (!locked && n < 200) begin
      send(1'b0, 1'b0);
      n++;
    end
    chk(name, n, N + LOCK_CNT + 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_locked", locked, e.lk);
        chk("sb_err", err, e.er);
        chk("sb_err_cnt", err_cnt, e.ec);
        chk("sb_bit_cnt", bit_cnt, e.bc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, cnt, pos[$];
    bit seen;
    gq.push_back(1'b1);
    for (int i = 1; i < N; i++) gq.push_back(1'b0);
    model_reset();

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    rst_n = 1'b1;

    lock_run("lock_latency");
    chk("lock_err_cnt", err_cnt, 0);

    // single error
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0);
    chk("pre_single_err_cnt", err_cnt, 0);
    send(1'b1, 1'b0);
    chk("single_err_pulse", err, 1);
    chk("single_err_cnt", err_cnt, 1);
    send(1'b0, 1'b0);
    chk("single_err_clears", err, 0);
    for (int i = 0; i < 50; i++) send(1'b0, 1'b0);
    chk("single_err_cnt_hold", err_cnt, 1);
    chk("single_still_locked", locked, 1);

    // align so the next bit is the window-wrap bit, then two windows of 15 errors
    n = 0;
    while (m_wn != WINDOW-1 && n < 2*WINDOW) begin send(1'b0, 1'b0); n++; end
    for (int w = 0; w < 2; w++) begin
      drive(1'b0, 1'b0, 1'b1);
      pos.delete();
      pos.push_back(0);
      for (int i = 1; i < ERR_THRESH-1; i++) pos.push_back(i*17 + $urandom_range(0, 15));
      for (int b = 0; b < WINDOW; b++) begin
        seen = 1'b0;
        foreach (pos[k]) if (pos[k] == b) seen = 1'b1;
        send(seen, 1'b0);
      end
      chk("win15_err_cnt", err_cnt, ERR_THRESH-1);
      chk("win15_locked", locked, 1);
    end

    // 16 errors in one window (first on the wrap bit) drop lock
    drive(1'b0, 1'b0, 1'b1);
    for (int b = 0; b < WINDOW; b++) send((b % 16) == 0, 1'b0);
    chk("win16_err_cnt", err_cnt, ERR_THRESH);
    chk("win16_unlocked", locked, 0);
    n = 0;
    while (!locked && n < 300) begin send(1'b0, 1'b0); n++; end
    chk("relock_after_loss", locked, 1);

    // random ce while locked
    drive(1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        send(1'b0, 1'b0);
        cnt++;
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk("ce0_err_low", err, 0);
      end
    end
    chk("rand_ce_bit_cnt", bit_cnt, cnt);
    chk("rand_ce_err_cnt", err_cnt, 0);

    // clr together with an error
    send(1'b1, 1'b1);
    chk("clr_err_pulse", err, 1);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_keeps_lock", locked, 1);

    // asynchronous reset while locked
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_bit_cnt", bit_cnt, 0);
    chk("async_rst_err", err, 0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    lock_run("relock_after_reset");

    // all-zero input never locks
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (locked) seen = 1'b1;
    end
    chk("zero_never_locks", seen, 0);

    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
